core_ctrl_fsm: RTL and testbench
================================

Name: core_ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32I single-issue datapath. It latches the fetched instruction, decodes it, and steps it through FETCH/DECODE/EXEC/MEM/WB, driving every datapath control input per state. It adds a PC write-enable (pc_en), data-memory wait-state handling, retired-instruction counting, and halt/trap on EBREAK, illegal opcode or memory timeout. It sits beside the datapath and replaces the combinational decoder.

Parameters:
INSTRET_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 16, max cycles in MEM waiting for mem_ready before trap (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr  in  32  instruction word from instruction memory at current PC
Br_eq  in  1  branch comparator equal
Br_lt  in  1  branch comparator less-than
mem_ready  in  1  data memory access complete (load data valid / store accepted)
pc_en  out  1  PC register load enable
PC_sel  out  1  0 = ALU_out, 1 = PC+1
reg_write_en  out  1  register file write
imm_src  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J
Br_un  out  1  0 = signed, 1 = unsigned compare
alu_src_A  out  1  0 = busA, 1 = PC
alu_src_B  out  1  0 = busB, 1 = imm
alu_control  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
mem_write_en  out  1  data memory write
mem_read_en  out  1  data memory read request
result_src  out  2  0 = mem, 1 = ALU, 2 = PC+1
state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT, 6 TRAP
halted  out  1  high in HALT
illegal  out  2  trap cause: 0 none, 1 bad opcode/funct, 2 mem timeout (sticky)
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async): state = FETCH, ir = 32'h00000013, instret = 0, illegal = 0, timeout counter = 0. All enables (pc_en, reg_write_en, mem_write_en, mem_read_en) = 0. Muxes: PC_sel = 1, others 0.
- FETCH: ir <= instr; go to DECODE. DECODE: classify ir[6:0]. Unknown opcode, or an invalid funct3/funct7 combination for OP/OP-IMM → TRAP with illegal = 1. Otherwise go to EXEC.
- Sequences, with cycles per instruction in brackets:
  - OP, OP-IMM, LUI, AUIPC: FETCH, DECODE, EXEC, WB [4].
  - LOAD: FETCH, DECODE, EXEC, MEM, WB [5 + wait].
  - STORE: FETCH, DECODE, EXEC, MEM [4 + wait].
  - BRANCH: FETCH, DECODE, EXEC [3].
  - JAL, JALR: FETCH, DECODE, EXEC, WB [4].
- EBREAK (32'h00100073) → HALT from DECODE; it does not retire. ECALL and other SYSTEM encodings → TRAP, illegal = 1.
- Control outputs depend on state and ir only. They are held stable from EXEC through the final state of the instruction. All enables are 0 in FETCH, DECODE, HALT and TRAP.
- ALU setup:
  - OP: alu_control from funct3, plus funct7[5] for SUB/SRA.
  - OP-IMM: same, except ADDI ignores funct7.
  - LUI: PASS_B with imm U.
  - AUIPC: A = PC, B = imm U, ADD.
  - LOAD/STORE: A = busA, B = imm I or S, ADD.
  - BRANCH, JAL: A = PC, imm B or J, ADD.
  - JALR: A = busA, imm I, ADD.
- MEM: mem_read_en (load) or mem_write_en (store) is held until mem_ready is sampled high.
  - Load → WB. Store → retire (pc_en = 1, PC_sel = 1) → FETCH.
  - The wait counter starts at 0 on MEM entry. If mem_ready is still low after MEM_TIMEOUT cycles in MEM → TRAP, illegal = 2, enables dropped.
- WB: reg_write_en = 1 and pc_en = 1 for one cycle.
  - result_src: 0 for load, 1 for ALU ops, 2 for JAL/JALR.
  - PC_sel: 0 for JAL/JALR, else 1.
  - Register write and PC update happen on the same edge.
- BRANCH in EXEC: Br_un = funct3[1]; pc_en = 1.
  - taken: BEQ eq, BNE !eq, BLT/BLTU lt, BGE/BGEU !lt.
  - PC_sel = 0 if taken, else 1.
  - funct3 010 or 011 → TRAP, illegal = 1 (detected at DECODE).
- Writes to rd = x0 still assert reg_write_en; the register file ignores them.
- instret increments by 1 on every cycle with pc_en = 1, and wraps to 0 at 2^INSTRET_W.
- pc_en is asserted exactly once per retired instruction.
- HALT and TRAP are sticky until rst. Reset asserted mid-instruction aborts immediately: no partial write completes after the reset edge.

Test Plan:
- Reset then ADDI x1,x0,5 (32'h00500093) → states 0,1,2,4. reg_write_en = 1, result_src = 1, alu_control = 0, alu_src_B = 1, pc_en = 1, all in WB only. instret = 1 after 4 cycles.
- LW with mem_ready low 3 cycles then high → mem_read_en high for 4 MEM cycles, then WB with result_src = 0. Total 8 cycles. Same LW with mem_ready held low → TRAP after 16 MEM cycles, illegal = 2, instret unchanged.
- BEQ: Br_eq = 1 → PC_sel = 0, pc_en = 1 in EXEC. Br_eq = 0 → PC_sel = 1. BLTU → Br_un = 1. Each completes in 3 cycles.
- JAL x1 (32'h008000EF) → in WB: result_src = 2, PC_sel = 0, reg_write_en = 1, pc_en = 1, imm_src = 4, alu_src_A = 1.
- Opcode 7'h7F → TRAP from DECODE, illegal = 1, no enables ever asserted. EBREAK → HALT, halted = 1, held for 20 cycles.
- Assert rst during MEM of a store → next cycle mem_write_en = 0, state = FETCH, instret = 0. Preload instret = all-ones, retire one instruction → instret = 0.

Source files
------------

// File: rtl/core_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// core_ctrl_fsm
//
// Multi-cycle control sequencer for the RV32I single-issue datapath. The
// instruction word is latched in FETCH, classified in DECODE, and then
// stepped through EXEC / MEM / WB. Every datapath control input is driven
// from the current state and the latched instruction. The block also
// provides:
//   - the PC load enable,
//   - data-memory wait-state handling with a timeout trap,
//   - a retired-instruction counter,
//   - halt on EBREAK and trap on illegal encodings.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   instr         : instruction word at the current PC (sampled in FETCH)
//   Br_eq, Br_lt  : branch comparator results
//   mem_ready     : data memory access complete
//   pc_en         : PC register load enable (one pulse per retirement)
//   PC_sel        : 0 = ALU_out, 1 = PC+1
//   reg_write_en  : register file write enable
//   imm_src       : 0 = I, 1 = S, 2 = B, 3 = U, 4 = J
//   Br_un         : 0 = signed compare, 1 = unsigned compare
//   alu_src_A     : 0 = busA, 1 = PC
//   alu_src_B     : 0 = busB, 1 = imm
//   alu_control   : ALU operation select (0 ADD ... 10 PASS_B)
//   mem_write_en  : data memory write request
//   mem_read_en   : data memory read request
//   result_src    : 0 = mem, 1 = ALU, 2 = PC+1
//   state         : 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT, 6 TRAP
//   halted        : high while in HALT
//   illegal       : sticky trap cause (0 none, 1 bad encoding, 2 mem timeout)
//   instret       : retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module core_ctrl_fsm #(
  parameter int INSTRET_W   = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 Br_eq,
  input  logic                 Br_lt,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 PC_sel,
  output logic                 reg_write_en,
  output logic [2:0]           imm_src,
  output logic                 Br_un,
  output logic                 alu_src_A,
  output logic                 alu_src_B,
  output logic [3:0]           alu_control,
  output logic                 mem_write_en,
  output logic                 mem_read_en,
  output logic [1:0]           result_src,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [1:0]           illegal,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LUI, C_AUIPC, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_EBREAK, C_BAD
  } iclass_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] IR_NOP      = 32'h0000_0013;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_MEM = 2'd0;
  localparam logic [1:0] RES_ALU = 2'd1;
  localparam logic [1:0] RES_PC1 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_BAD     = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // The counter must be able to hold MEM_TIMEOUT itself for one cycle on the
  // way into TRAP, hence the +1 in the width.
  localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [31:0]          ir;
  logic [1:0]           illegal_q, illegal_d;
  logic [CNT_W-1:0]     wait_cnt;
  logic [INSTRET_W-1:0] instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  iclass_t    ir_class;
  logic [3:0] dec_alu;
  logic [2:0] dec_imm;
  logic       dec_src_a;
  logic       dec_src_b;
  logic [1:0] dec_result;
  logic       dec_pc_sel;
  logic       br_taken;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // Register/immediate ALU operations share one funct3 table; 'alt' selects
  // SUB over ADD and SRA over SRL.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Instruction classification and the static datapath setup that goes with
  // it. These values only reach the outputs from EXEC onward, so they stay
  // constant for the remainder of the instruction.
  always_comb begin
    ir_class   = C_BAD;
    dec_alu    = ALU_ADD;
    dec_imm    = IMM_I;
    dec_src_a  = 1'b0;
    dec_src_b  = 1'b1;
    dec_result = RES_ALU;
    dec_pc_sel = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_src_b = 1'b0;
        dec_alu   = alu_from_funct3(funct3, funct7[5]);
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
          ir_class = C_OP;
      end
      OPC_OPIMM: begin
        // Only the shift-immediates carry a real funct7; every other
        // OP-IMM form uses those bits as part of the immediate.
        dec_alu  = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        ir_class = C_OPIMM;
        if (funct3 == 3'b001 && funct7 != 7'h00)
          ir_class = C_BAD;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
          ir_class = C_BAD;
      end
      OPC_LUI: begin
        ir_class = C_LUI;
        dec_alu  = ALU_PASS_B;
        dec_imm  = IMM_U;
      end
      OPC_AUIPC: begin
        ir_class  = C_AUIPC;
        dec_src_a = 1'b1;
        dec_imm   = IMM_U;
      end
      OPC_LOAD: begin
        ir_class   = C_LOAD;
        dec_result = RES_MEM;
      end
      OPC_STORE: begin
        ir_class = C_STORE;
        dec_imm  = IMM_S;
      end
      OPC_BRANCH: begin
        if (funct3[2:1] != 2'b01)
          ir_class = C_BRANCH;
        dec_src_a = 1'b1;
        dec_imm   = IMM_B;
      end
      OPC_JAL: begin
        ir_class   = C_JAL;
        dec_src_a  = 1'b1;
        dec_imm    = IMM_J;
        dec_result = RES_PC1;
        dec_pc_sel = 1'b0;
      end
      OPC_JALR: begin
        ir_class   = C_JALR;
        dec_result = RES_PC1;
        dec_pc_sel = 1'b0;
      end
      OPC_SYSTEM: begin
        if (ir == EBREAK_WORD)
          ir_class = C_EBREAK;
      end
      default: ;
    endcase
  end

  // Branch resolution from the comparator flags; the signed/unsigned
  // variants differ only in Br_un, so funct3[1] is ignored here.
  always_comb begin
    case (funct3)
      3'b000:         br_taken = Br_eq;
      3'b001:         br_taken = !Br_eq;
      3'b100, 3'b110: br_taken = Br_lt;
      3'b101, 3'b111: br_taken = !Br_lt;
      default:        br_taken = 1'b0;
    endcase
  end

  // Next-state and control output logic. Everything starts at the idle
  // values (enables off, PC_sel = PC+1) so FETCH, DECODE, HALT and TRAP
  // never drive a write. The store retirement and branch PC_sel are the
  // only outputs that also look at a live input.
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    pc_en        = 1'b0;
    PC_sel       = 1'b1;
    reg_write_en = 1'b0;
    imm_src      = IMM_I;
    Br_un        = 1'b0;
    alu_src_A    = 1'b0;
    alu_src_B    = 1'b0;
    alu_control  = ALU_ADD;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    result_src   = RES_MEM;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      imm_src     = dec_imm;
      alu_src_A   = dec_src_a;
      alu_src_B   = dec_src_b;
      alu_control = dec_alu;
      result_src  = dec_result;
      PC_sel      = dec_pc_sel;
      Br_un       = (ir_class == C_BRANCH) && funct3[1];
    end

    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (ir_class)
          C_EBREAK: state_d = S_HALT;
          C_BAD: begin
            state_d   = S_TRAP;
            illegal_d = CAUSE_BAD;
          end
          default:  state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (ir_class)
          C_BRANCH: begin
            pc_en   = 1'b1;
            PC_sel  = !br_taken;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (ir_class == C_LOAD)
          mem_read_en = 1'b1;
        else
          mem_write_en = 1'b1;
        if (mem_ready) begin
          if (ir_class == C_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_cnt == CNT_LAST) begin
          state_d   = S_TRAP;
          illegal_d = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        reg_write_en = 1'b1;
        pc_en        = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      S_TRAP: state_d = S_TRAP;
      default: begin
        state_d   = S_TRAP;
        illegal_d = CAUSE_BAD;
      end
    endcase
  end

  // State, instruction register, trap cause, memory wait counter and the
  // retirement counter. The wait counter is held at zero outside MEM so each
  // memory access gets a fresh MEM_TIMEOUT-cycle budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir        <= IR_NOP;
      illegal_q <= CAUSE_NONE;
      wait_cnt  <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == S_FETCH)
        ir <= instr;
      if (state_q == S_MEM && !mem_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;
      if (pc_en)
        instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_core_ctrl_fsm
//
// Directed and randomized bench for core_ctrl_fsm. Expected behaviour comes
// from an instruction-level reference model: each instruction is turned into
// the list of states it should visit and its datapath setup, and every cycle
// is compared against that list. The counter is narrowed to 4 bits so the
// wrap from all-ones to zero is reached quickly.
// ---------------------------------------------------------------------------
module tb_core_ctrl_fsm;

  localparam int IW  = 4;
  localparam int TMO = 16;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3;
  localparam int K_JUMP = 4, K_HALT = 5, K_BAD = 6;
  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3;
  localparam int ST_WB = 4, ST_HALT = 5, ST_TRAP = 6;

  typedef struct {
    int kind;
    int alu;
    int imm;
    int src_a;
    int src_b;
    int res;
    int chk_res;
    int jump;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [31:0]   instr;
  logic          Br_eq;
  logic          Br_lt;
  logic          mem_ready;
  logic          pc_en;
  logic          PC_sel;
  logic          reg_write_en;
  logic [2:0]    imm_src;
  logic          Br_un;
  logic          alu_src_A;
  logic          alu_src_B;
  logic [3:0]    alu_control;
  logic          mem_write_en;
  logic          mem_read_en;
  logic [1:0]    result_src;
  logic [2:0]    state;
  logic          halted;
  logic [1:0]    illegal;
  logic [IW-1:0] instret;

  int n_checks      = 0;
  int n_fail        = 0;
  int model_instret = 0;

  core_ctrl_fsm #(.INSTRET_W(IW), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .Br_eq        (Br_eq),
    .Br_lt        (Br_lt),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .PC_sel       (PC_sel),
    .reg_write_en (reg_write_en),
    .imm_src      (imm_src),
    .Br_un        (Br_un),
    .alu_src_A    (alu_src_A),
    .alu_src_B    (alu_src_B),
    .alu_control  (alu_control),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .result_src   (result_src),
    .state        (state),
    .halted       (halted),
    .illegal      (illegal),
    .instret      (instret)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and counts and reports it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: instruction class and datapath setup per RV32I rules.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   op, f3, f7;
    int   alu_tab [8];
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    e.kind = K_BAD; e.alu = 0; e.imm = 0; e.src_a = 0; e.src_b = 1;
    e.res = 1; e.chk_res = 1; e.jump = 0;
    case (op)
      'h33: begin
        e.src_b = 0;
        if (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))) begin
          e.kind = K_ALU;
          e.alu  = alu_tab[f3] + ((f7 == 'h20) ? 1 : 0);
        end
      end
      'h13: begin
        if (!((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20))) begin
          e.kind = K_ALU;
          e.alu  = alu_tab[f3] + ((f3 == 5 && f7 == 'h20) ? 1 : 0);
        end
      end
      'h37: begin e.kind = K_ALU; e.alu = 10; e.imm = 3; end
      'h17: begin e.kind = K_ALU; e.src_a = 1; e.imm = 3; end
      'h03: begin e.kind = K_LOAD; e.res = 0; end
      'h23: begin e.kind = K_STORE; e.imm = 1; e.chk_res = 0; end
      'h63: begin
        if (f3 != 2 && f3 != 3) e.kind = K_BRANCH;
        e.src_a = 1; e.imm = 2; e.chk_res = 0;
      end
      'h6F: begin e.kind = K_JUMP; e.src_a = 1; e.imm = 4; e.res = 2; e.jump = 1; end
      'h67: begin e.kind = K_JUMP; e.res = 2; e.jump = 1; end
      'h73: if (w == 32'h0010_0073) e.kind = K_HALT;
      default: ;
    endcase
    return e;
  endfunction

  // Branch outcome from the mnemonic: BEQ, BNE, BLT(U), BGE(U).
  function automatic bit branch_taken(input int f3, input logic eq, input logic lt);
    if (f3 == 0) return eq;
    if (f3 == 1) return !eq;
    if (f3 == 4 || f3 == 6) return lt;
    return !lt;
  endfunction

  // Reset for one cycle; the idle output values are checked while reset is
  // held. Reset is released mid-cycle, so the bench resumes in a FETCH cycle.
  task automatic doReset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #2;
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_pc_en", 32'(pc_en), 0);
    checkOutput("rst_reg_we", 32'(reg_write_en), 0);
    checkOutput("rst_mem_re", 32'(mem_read_en), 0);
    checkOutput("rst_mem_we", 32'(mem_write_en), 0);
    checkOutput("rst_pc_sel", 32'(PC_sel), 1);
    checkOutput("rst_result_src", 32'(result_src), 0);
    checkOutput("rst_alu_control", 32'(alu_control), 0);
    checkOutput("rst_imm_src", 32'(imm_src), 0);
    checkOutput("rst_alu_src", 32'({alu_src_A, alu_src_B, Br_un}), 0);
    checkOutput("rst_halted", 32'(halted), 0);
    checkOutput("rst_illegal", 32'(illegal), 0);
    checkOutput("rst_instret", 32'(instret), 0);
    rst = 1'b0;
    model_instret = 0;
  endtask

  // Runs one instruction starting in a FETCH cycle. lat is the number of
  // MEM cycles with mem_ready low before it goes high (-1: never).
  task automatic applyStimulus(input logic [31:0] w, input int lat, input logic eq,
                               input logic lt, input string tag);
    exp_t e;
    int   seq[$];
    int   cause;
    int   mem_idx;
    int   st;
    bit   retire;
    bit   taken;
    bit   exp_pc;
    int   exp_pc_sel;
    e = model(w);
    cause = 0;
    mem_idx = 0;
    seq.push_back(ST_FETCH);
    seq.push_back(ST_DECODE);
    case (e.kind)
      K_BAD:    begin seq.push_back(ST_TRAP); cause = 1; end
      K_HALT:   seq.push_back(ST_HALT);
      K_BRANCH: seq.push_back(ST_EXEC);
      K_LOAD, K_STORE: begin
        seq.push_back(ST_EXEC);
        if (lat < 0 || lat >= TMO) begin
          repeat (TMO) seq.push_back(ST_MEM);
          seq.push_back(ST_TRAP);
          cause = 2;
        end else begin
          repeat (lat + 1) seq.push_back(ST_MEM);
          if (e.kind == K_LOAD) seq.push_back(ST_WB);
        end
      end
      default:  begin seq.push_back(ST_EXEC); seq.push_back(ST_WB); end
    endcase
    retire = (seq[$] != ST_HALT && seq[$] != ST_TRAP);
    taken  = branch_taken(int'(w[14:12]), eq, lt);
    Br_eq  = eq;
    Br_lt  = lt;
    instr  = w;
    for (int c = 0; c < seq.size(); c++) begin
      st = seq[c];
      if (c == 1) instr = $urandom;
      if (st == ST_MEM) begin
        mem_ready = (mem_idx == lat);
        mem_idx++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      exp_pc = retire && (c == seq.size() - 1);
      checkOutput($sformatf("%s_c%0d_state", tag, c), 32'(state), 32'(st));
      checkOutput($sformatf("%s_c%0d_pc_en", tag, c), 32'(pc_en), 32'(exp_pc));
      checkOutput($sformatf("%s_c%0d_reg_we", tag, c), 32'(reg_write_en), 32'(st == ST_WB));
      checkOutput($sformatf("%s_c%0d_mem_re", tag, c), 32'(mem_read_en),
                  32'(st == ST_MEM && e.kind == K_LOAD));
      checkOutput($sformatf("%s_c%0d_mem_we", tag, c), 32'(mem_write_en),
                  32'(st == ST_MEM && e.kind == K_STORE));
      checkOutput($sformatf("%s_c%0d_halted", tag, c), 32'(halted), 32'(st == ST_HALT));
      checkOutput($sformatf("%s_c%0d_illegal", tag, c), 32'(illegal),
                  32'((st == ST_TRAP) ? cause : 0));
      if (st == ST_EXEC || st == ST_MEM || st == ST_WB) begin
        exp_pc_sel = (e.kind == K_BRANCH) ? (taken ? 0 : 1) : (e.jump ? 0 : 1);
        checkOutput($sformatf("%s_c%0d_alu", tag, c), 32'(alu_control), 32'(e.alu));
        checkOutput($sformatf("%s_c%0d_imm", tag, c), 32'(imm_src), 32'(e.imm));
        checkOutput($sformatf("%s_c%0d_src_a", tag, c), 32'(alu_src_A), 32'(e.src_a));
        checkOutput($sformatf("%s_c%0d_src_b", tag, c), 32'(alu_src_B), 32'(e.src_b));
        checkOutput($sformatf("%s_c%0d_pc_sel", tag, c), 32'(PC_sel), 32'(exp_pc_sel));
        if (e.chk_res != 0)
          checkOutput($sformatf("%s_c%0d_result", tag, c), 32'(result_src), 32'(e.res));
        if (e.kind == K_BRANCH)
          checkOutput($sformatf("%s_c%0d_br_un", tag, c), 32'(Br_un), 32'(w[13]));
      end else begin
        checkOutput($sformatf("%s_c%0d_pc_sel_idle", tag, c), 32'(PC_sel), 1);
      end
      @(posedge clk); #2;
      if (exp_pc) model_instret = (model_instret + 1) % (1 << IW);
    end
    mem_ready = 1'b0;
    checkOutput({tag, "_instret"}, 32'(instret), 32'(model_instret));
  endtask

  // Stays in a terminal state for n cycles while the inputs wander.
  task automatic holdCheck(input int n, input int st, input int cause, input string tag);
    for (int c = 0; c < n; c++) begin
      instr = $urandom;
      mem_ready = 1'($urandom);
      Br_eq = 1'($urandom);
      Br_lt = 1'($urandom);
      #1;
      checkOutput($sformatf("%s_h%0d_state", tag, c), 32'(state), 32'(st));
      checkOutput($sformatf("%s_h%0d_halted", tag, c), 32'(halted), 32'(st == ST_HALT));
      checkOutput($sformatf("%s_h%0d_illegal", tag, c), 32'(illegal), 32'(cause));
      checkOutput($sformatf("%s_h%0d_enables", tag, c),
                  32'({pc_en, reg_write_en, mem_read_en, mem_write_en}), 0);
      @(posedge clk); #2;
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  ops [10];
    int          pick, lat, sel;
    exp_t        e;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73};
    rst = 1'b1; instr = 32'h0; Br_eq = 1'b0; Br_lt = 1'b0; mem_ready = 1'b0;

    $display("[TB] directed sequences");
    doReset();
    applyStimulus(32'h0050_0093, 0, 1'b0, 1'b0, "addi");
    checkOutput("addi_instret_one", 32'(instret), 1);
    applyStimulus(32'h0000_A103, 3, 1'b0, 1'b0, "lw_wait3");
    applyStimulus(32'h0020_A023, 0, 1'b0, 1'b0, "sw_nowait");
    applyStimulus(32'h0020_A023, 2, 1'b0, 1'b0, "sw_wait2");
    applyStimulus(32'h0020_8463, 0, 1'b1, 1'b0, "beq_taken");
    applyStimulus(32'h0020_8463, 0, 1'b0, 1'b1, "beq_not");
    applyStimulus(32'h0020_E463, 0, 1'b0, 1'b1, "bltu_taken");
    applyStimulus(32'h0080_00EF, 0, 1'b0, 1'b0, "jal");
    applyStimulus(32'h0000_80E7, 0, 1'b0, 1'b0, "jalr");
    applyStimulus(32'h1234_50B7, 0, 1'b0, 1'b0, "lui");
    applyStimulus(32'h0000_1117, 0, 1'b0, 1'b0, "auipc");
    applyStimulus(32'h4020_81B3, 0, 1'b0, 1'b0, "sub");
    applyStimulus(32'h4020_D1B3, 0, 1'b0, 1'b0, "sra");
    applyStimulus(32'h4030_D093, 0, 1'b0, 1'b0, "srai");
    applyStimulus(32'hFFF0_C093, 0, 1'b0, 1'b0, "xori");

    // Instret wraps from all-ones back to zero.
    while (model_instret != (1 << IW) - 1)
      applyStimulus(32'h0050_0093, 0, 1'b0, 1'b0, "addi_fill");
    checkOutput("instret_all_ones", 32'(instret), 32'((1 << IW) - 1));
    applyStimulus(32'h0050_0093, 0, 1'b0, 1'b0, "addi_wrap");
    checkOutput("instret_wrapped", 32'(instret), 0);

    // Reset while a store is waiting in MEM.
    doReset();
    applyStimulus(32'h0050_0093, 0, 1'b0, 1'b0, "pre_abort");
    instr = 32'h0020_A023;
    mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    #1;
    checkOutput("abort_in_mem", 32'(state), 3);
    checkOutput("abort_mem_we_before", 32'(mem_write_en), 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_mem_we", 32'(mem_write_en), 0);
    checkOutput("abort_state", 32'(state), 0);
    checkOutput("abort_instret", 32'(instret), 0);
    @(posedge clk); #2;
    checkOutput("abort_state_held", 32'(state), 0);
    checkOutput("abort_enables", 32'({pc_en, reg_write_en, mem_read_en, mem_write_en}), 0);
    rst = 1'b0;
    model_instret = 0;
    applyStimulus(32'h0050_0093, 0, 1'b0, 1'b0, "post_abort");

    applyStimulus(32'h0000_A103, -1, 1'b0, 1'b0, "lw_timeout");
    holdCheck(4, ST_TRAP, 2, "lw_timeout");
    doReset();
    applyStimulus(32'h0000_007F, 0, 1'b0, 1'b0, "bad_opcode");
    holdCheck(4, ST_TRAP, 1, "bad_opcode");
    doReset();
    applyStimulus(32'h4020_91B3, 0, 1'b0, 1'b0, "bad_funct7");
    holdCheck(2, ST_TRAP, 1, "bad_funct7");
    doReset();
    applyStimulus(32'h0020_A463, 0, 1'b0, 1'b0, "bad_branch");
    holdCheck(2, ST_TRAP, 1, "bad_branch");
    doReset();
    applyStimulus(32'h0000_0073, 0, 1'b0, 1'b0, "ecall");
    holdCheck(2, ST_TRAP, 1, "ecall");
    doReset();
    applyStimulus(32'h0010_0073, 0, 1'b0, 1'b0, "ebreak");
    holdCheck(20, ST_HALT, 0, "ebreak");
    checkOutput("ebreak_no_retire", 32'(instret), 0);

    $display("[TB] randomized sequences");
    doReset();
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      pick = $urandom_range(0, 10);
      if (pick < 10) w[6:0] = ops[pick];
      if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
        sel = $urandom_range(0, 3);
        if (sel == 0) w[31:25] = 7'h00;
        else if (sel == 1) w[31:25] = 7'h20;
      end
      if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) w = 32'h0010_0073;
      lat = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 4);
      applyStimulus(w, lat, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
      e = model(w);
      if (e.kind == K_HALT) begin
        holdCheck(2, ST_HALT, 0, $sformatf("rnd%0d", n));
        doReset();
      end else if (e.kind == K_BAD) begin
        holdCheck(2, ST_TRAP, 1, $sformatf("rnd%0d", n));
        doReset();
      end else if ((e.kind == K_LOAD || e.kind == K_STORE) && lat < 0) begin
        holdCheck(2, ST_TRAP, 2, $sformatf("rnd%0d", n));
        doReset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
